// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the slow-clock measurement scheduler.
package clk_meas_pkg;
  localparam int CNT_W = 16;
  localparam int ACC_W = CNT_W + 4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_SETTLE, ST_MEASURE, ST_REPORT
  } state_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_narrow(input logic [ACC_W-1:0] v);
    return (|v[ACC_W-1:CNT_W]) ? {CNT_W{1'b1}} : v[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/clk_meas_sched_if.sv
// Result channel of the measurement scheduler: valid/ready plus payload.
interface clk_meas_sched_if;
  import clk_meas_pkg::*;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_ch;
  logic [CNT_W-1:0] res_ht;
  logic [CNT_W-1:0] res_lt;
  logic             res_timeout;

  modport master (output res_valid, res_ch, res_ht, res_lt, res_timeout, input res_ready);
  modport slave  (input res_valid, res_ch, res_ht, res_lt, res_timeout, output res_ready);
endinterface

// File: rtl/clk_hilo_counter.sv
// Per-period high/low cycle counter on a synchronized slow-clock sample.
module clk_hilo_counter
  import clk_meas_pkg::*;
(
  input  logic             clk_fst,
  input  logic             reset_n,
  input  logic             smp,
  input  logic             clr,
  output logic             period_done,
  output logic             rise,
  output logic [CNT_W-1:0] ht,
  output logic [CNT_W-1:0] lt
);
  logic             prev, armed, lo_seen, fall;
  logic [CNT_W-1:0] ht_cnt, lt_cnt;

  assign rise        = smp & ~prev;
  assign fall        = ~smp & prev;
  assign period_done = rise & armed & lo_seen;
  assign ht          = ht_cnt;
  assign lt          = lt_cnt;

  // prev is forced high on clear so a mux switch can never fake a rising edge
  always_ff @(posedge clk_fst) begin
    if (!reset_n || clr) begin
      prev    <= 1'b1;
      armed   <= 1'b0;
      lo_seen <= 1'b0;
      ht_cnt  <= '0;
      lt_cnt  <= '0;
    end else begin
      prev <= smp;
      if (rise) begin
        armed   <= 1'b1;
        lo_seen <= 1'b0;
        ht_cnt  <= CNT_W'(1);
        lt_cnt  <= '0;
      end else if (fall && armed) begin
        lo_seen <= 1'b1;
        lt_cnt  <= CNT_W'(1);
      end else if (armed && smp && !lo_seen) begin
        ht_cnt <= sat_add(ht_cnt, CNT_W'(1));
      end else if (armed && !smp && lo_seen) begin
        lt_cnt <= sat_add(lt_cnt, CNT_W'(1));
      end
    end
  end
endmodule

// File: rtl/clk_meas_sched.sv
// Scans masked slow clocks one at a time through a shared high/low counter.
module clk_meas_sched
  import clk_meas_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int SETTLE_PERIODS = 2,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT        = 65535
) (
  input  logic            clk_fst,
  input  logic            reset_n,
  input  logic [N_CH-1:0] clk_slw_in,
  input  logic            start,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            continuous,
  output logic            busy,
  output logic            done,
  clk_meas_sched_if.master res
);
  localparam int              AVG_N    = 1 << AVG_LOG2;
  localparam int              TO_W     = $clog2(TIMEOUT + 1);
  localparam int              PC_W     = 16;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [PC_W-1:0] SET_LAST = PC_W'(SETTLE_PERIODS - 1);
  localparam logic [PC_W-1:0] AVG_LAST = PC_W'(AVG_N - 1);

  state_t           state, state_n;
  logic [N_CH-1:0]  sync1, sync2, mask_q;
  logic [15:0]      sync_pad;
  logic [3:0]       ch_idx, ch_n, lo_idx_m, lo_idx_q, nxt_idx;
  logic             has_nxt, smp_q, done_n, counting, tmo, meas_fin;
  logic             period_done, rise;
  logic [CNT_W-1:0] ht, lt;
  logic [TO_W-1:0]  to_cnt;
  logic [PC_W-1:0]  per_cnt;
  logic [ACC_W-1:0] sum_ht, sum_lt, acc_ht, acc_lt;

  clk_hilo_counter u_cnt (
    .clk_fst, .reset_n, .smp(smp_q), .clr(state == ST_SELECT),
    .period_done, .rise, .ht, .lt
  );

  assign sync_pad      = 16'(sync2);
  assign busy          = (state != ST_IDLE);
  assign res.res_valid = (state == ST_REPORT);
  assign res.res_ch    = ch_idx;
  assign counting      = (state == ST_SETTLE) || (state == ST_MEASURE);
  // an edge landing on the terminal count wins over the timeout
  assign tmo           = counting && (to_cnt == TO_LAST) && !rise;
  assign meas_fin      = (state == ST_MEASURE) && period_done && (per_cnt == AVG_LAST);
  assign acc_ht        = sum_ht + ACC_W'(ht);
  assign acc_lt        = sum_lt + ACC_W'(lt);

  // lowest set bit of the new and latched masks, and next set bit above ch_idx
  always_comb begin
    lo_idx_m = '0;
    lo_idx_q = '0;
    nxt_idx  = '0;
    has_nxt  = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) lo_idx_m = 4'(i);
      if (mask_q[i])  lo_idx_q = 4'(i);
      if (mask_q[i] && (4'(i) > ch_idx)) begin
        has_nxt = 1'b1;
        nxt_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    ch_n    = ch_idx;
    done_n  = 1'b0;
    case (state)
      ST_IDLE:
        if (start) begin
          if (|ch_mask) begin
            state_n = ST_SELECT;
            ch_n    = lo_idx_m;
          end else begin
            done_n = 1'b1;
          end
        end
      ST_SELECT: state_n = (SETTLE_PERIODS == 0) ? ST_MEASURE : ST_SETTLE;
      ST_SETTLE:
        if (period_done && (per_cnt == SET_LAST)) state_n = ST_MEASURE;
        else if (tmo)                             state_n = ST_REPORT;
      ST_MEASURE:
        if (meas_fin || tmo) state_n = ST_REPORT;
      ST_REPORT:
        if (res.res_ready) begin
          if (has_nxt) begin
            state_n = ST_SELECT;
            ch_n    = nxt_idx;
          end else if (continuous) begin
            state_n = ST_SELECT;
            ch_n    = lo_idx_q;
          end else begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_fst) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      sync1           <= '0;
      sync2           <= '0;
      mask_q          <= '0;
      ch_idx          <= '0;
      smp_q           <= 1'b0;
      done            <= 1'b0;
      to_cnt          <= '0;
      per_cnt         <= '0;
      sum_ht          <= '0;
      sum_lt          <= '0;
      res.res_ht      <= '0;
      res.res_lt      <= '0;
      res.res_timeout <= 1'b0;
    end else begin
      state  <= state_n;
      sync1  <= clk_slw_in;
      sync2  <= sync1;
      ch_idx <= ch_n;
      smp_q  <= sync_pad[ch_idx];
      done   <= done_n;
      if (state == ST_IDLE && start) mask_q <= ch_mask;

      if (state == ST_SELECT || rise) to_cnt <= '0;
      else if (counting)              to_cnt <= to_cnt + TO_W'(1);

      if (state == ST_SELECT || (state == ST_SETTLE && state_n == ST_MEASURE)) per_cnt <= '0;
      else if (period_done)                                                   per_cnt <= per_cnt + PC_W'(1);

      if (state == ST_SELECT) begin
        sum_ht <= '0;
        sum_lt <= '0;
      end else if (state == ST_MEASURE && period_done) begin
        sum_ht <= acc_ht;
        sum_lt <= acc_lt;
      end

      if (meas_fin) begin
        res.res_ht      <= sat_narrow(acc_ht >> AVG_LOG2);
        res.res_lt      <= sat_narrow(acc_lt >> AVG_LOG2);
        res.res_timeout <= 1'b0;
      end else if (tmo) begin
        res.res_ht      <= '0;
        res.res_lt      <= '0;
        res.res_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_clk_meas_sched.sv
// Scoreboard bench: generated slow clocks, reference results from their programmed timing.
module tb_clk_meas_sched;
  localparam int N_CH = 4, SETTLE = 2, AVG_LOG2 = 2, TIMEOUT = 1000;

  typedef struct packed {
    logic [3:0]  ch;
    logic [15:0] ht;
    logic [15:0] lt;
    logic        tmo;
  } res_t;

  logic            clk_fst = 1'b0, reset_n = 1'b0, start = 1'b0, continuous = 1'b0;
  logic            busy, done;
  logic [N_CH-1:0] clk_slw_in = '0, ch_mask = '0;

  int   hi_t[N_CH] = '{8, 9, 5, 4};
  int   lo_t[N_CH] = '{12, 9, 5, 7};
  int   jit[N_CH]  = '{0, 1, 0, 2};
  int   n_vec, n_err, hs_cnt;
  bit   rdy_fix, rdy_rand;
  res_t exp_q[$];

  clk_meas_sched_if ifc();

  clk_meas_sched #(.N_CH(N_CH), .SETTLE_PERIODS(SETTLE), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk_fst(clk_fst), .reset_n(reset_n), .clk_slw_in(clk_slw_in), .start(start),
    .ch_mask(ch_mask), .continuous(continuous), .busy(busy), .done(done), .res(ifc.master)
  );

  always #5 clk_fst = ~clk_fst;

  // Expected result: mean of four consecutive periods whose high time alternates hi, hi+jit
  function automatic res_t model(input int c);
    res_t r;
    r.ch = 4'(c);
    if (hi_t[c] == 0 || lo_t[c] == 0) begin
      r.ht = '0; r.lt = '0; r.tmo = 1'b1;
    end else begin
      r.ht = 16'((4 * hi_t[c] + 2 * jit[c]) / 4);
      r.lt = 16'(lo_t[c]);
      r.tmo = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [39:0] outs();
    return {busy, done, ifc.res_valid, ifc.res_ch, ifc.res_ht, ifc.res_lt, ifc.res_timeout};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic gen_slow();
    int cnt[N_CH];
    bit par[N_CH];
    forever begin
      @(negedge clk_fst);
      for (int c = 0; c < N_CH; c++) begin
        if (hi_t[c] == 0)            clk_slw_in[c] = 1'b0;
        else if (lo_t[c] == 0)       clk_slw_in[c] = 1'b1;
        else if (cnt[c] > 1)         cnt[c]--;
        else if (clk_slw_in[c]) begin clk_slw_in[c] = 1'b0; cnt[c] = lo_t[c]; end
        else begin
          clk_slw_in[c] = 1'b1;
          par[c] = ~par[c];
          cnt[c] = hi_t[c] + (par[c] ? jit[c] : 0);
        end
      end
    end
  endtask

  task automatic rdy_drv();
    ifc.res_ready = 1'b0;
    forever begin
      @(posedge clk_fst); #2;
      ifc.res_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  endtask

  task automatic monitor();
    res_t got, e;
    forever begin
      @(negedge clk_fst);
      if (reset_n && done) chk("busy_low_at_done", 64'(busy), 64'(0));
      if (reset_n && ifc.res_valid && ifc.res_ready) begin
        hs_cnt++;
        got = {ifc.res_ch, ifc.res_ht, ifc.res_lt, ifc.res_timeout};
        chk("result_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", 64'(got), 64'(e));
        end
      end
    end
  endtask

  task automatic do_start(input logic [N_CH-1:0] m, input logic cont);
    ch_mask = m; continuous = cont; start = 1'b1;
    @(posedge clk_fst); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    while (!ifc.res_valid && lat < budget) begin @(posedge clk_fst); #1; lat++; end
    chk("valid_seen", 64'(ifc.res_valid), 64'(1));
  endtask

  task automatic wait_done(input int budget, input bit expect_busy);
    int   cyc;
    logic last_busy;
    cyc = 0; last_busy = busy;
    while (!done && cyc < budget) begin last_busy = busy; @(posedge clk_fst); #1; cyc++; end
    chk("done_seen", 64'(done), 64'(1));
    if (expect_busy) chk("busy_falls_with_done", 64'({last_busy, busy}), 64'(2'b10));
    @(posedge clk_fst); #1;
    chk("done_single_pulse", 64'(done), 64'(0));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_scan(input logic [N_CH-1:0] m);
    for (int c = 0; c < N_CH; c++) if (m[c]) exp_q.push_back(model(c));
    do_start(m, 1'b0);
    wait_done(30000, 1'b1);
  endtask

  initial begin
    int          lat, base;
    logic [39:0] snap;
    bit          stable;
    n_vec = 0; n_err = 0; hs_cnt = 0; rdy_fix = 1'b1; rdy_rand = 1'b0;
    fork
      gen_slow();
      monitor();
      rdy_drv();
    join_none

    repeat (4) @(posedge clk_fst); #1;
    chk("reset_state", 64'(outs()), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(posedge clk_fst); #1;

    // two channels, full-rate consumer
    run_scan(4'b0101);

    // dead channel times out
    hi_t[1] = 0;
    exp_q.push_back(model(1));
    do_start(4'b0010, 1'b0);
    wait_valid(3000, lat);
    chk("timeout_latency", 64'(lat >= 995 && lat <= 1010), 64'(1));
    wait_done(3000, 1'b1);
    hi_t[1] = 9;

    // backpressure holds the result
    rdy_fix = 1'b0;
    exp_q.push_back(model(0));
    exp_q.push_back(model(2));
    do_start(4'b0101, 1'b0);
    wait_valid(3000, lat);
    snap = outs();
    stable = 1'b1;
    repeat (50) begin @(posedge clk_fst); #1; if (outs() !== snap) stable = 1'b0; end
    chk("bp_outputs_held", 64'(stable), 64'(1));
    rdy_fix = 1'b1;
    @(posedge clk_fst); #1;
    chk("bp_valid_drops", 64'(ifc.res_valid), 64'(0));
    chk("bp_next_channel", 64'({busy, ifc.res_ch}), 64'({1'b1, 4'd2}));
    wait_done(30000, 1'b1);

    // empty mask
    do_start(4'b0000, 1'b0);
    chk("empty_done", 64'({done, busy}), 64'(2'b10));
    @(posedge clk_fst); #1;
    chk("empty_done_clear", 64'({done, busy}), 64'(0));

    // start while busy is ignored
    exp_q.push_back(model(0));
    do_start(4'b0001, 1'b0);
    repeat (30) @(posedge clk_fst); #1;
    do_start(4'b1110, 1'b0);
    wait_done(30000, 1'b1);

    // continuous on one channel, then let the scan stop
    for (int k = 0; k < 3; k++) exp_q.push_back(model(3));
    base = hs_cnt;
    do_start(4'b1000, 1'b1);
    lat = 0;
    while (hs_cnt < base + 2 && lat < 20000) begin @(posedge clk_fst); #1; lat++; end
    continuous = 1'b0;
    wait_done(20000, 1'b1);
    chk("continuous_count", 64'(hs_cnt - base), 64'(3));

    // reset mid-measure, then a fresh scan must settle again
    hi_t[0] = 6; lo_t[0] = 6; jit[0] = 0;
    repeat (30) @(posedge clk_fst); #1;
    exp_q.push_back(model(0));
    do_start(4'b0001, 1'b0);
    repeat (55) @(posedge clk_fst); #1;
    reset_n = 1'b0;
    @(posedge clk_fst); #1;
    chk("reset_mid_scan", 64'(outs()), 64'(0));
    exp_q.delete();
    reset_n = 1'b1;
    @(posedge clk_fst); #1;
    exp_q.push_back(model(0));
    do_start(4'b0001, 1'b0);
    wait_valid(3000, lat);
    chk("restart_settles", 64'(lat >= 70), 64'(1));
    wait_done(3000, 1'b1);

    // randomized timing, masks and consumer
    rdy_rand = 1'b1;
    for (int it = 0; it < 10; it++) begin
      for (int c = 0; c < N_CH; c++) begin
        hi_t[c] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
        lo_t[c] = int'($urandom_range(1, 12));
        jit[c]  = int'($urandom_range(0, 3));
      end
      repeat (30) @(posedge clk_fst); #1;
      run_scan(4'($urandom_range(1, 15)));
    end
    rdy_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/clk_meas_sched.md
# clk_meas_sched

Measurement scheduler for the slow-clock high/low-time counters. It sequences one shared high/low counter across up to N_CH candidate slow clocks, one channel at a time: select, discard settling periods, average high/low times over 2^AVG_LOG2 periods, report via valid/ready. It sits between the MMCM reconfiguration logic and the AXI status registers, and lets software verify every reconfigured output clock with a single start pulse.

## Interface
- N_CH, 4: number of slow-clock channels, 1..16.
- SETTLE_PERIODS, 2: complete periods discarded after each channel switch.
- AVG_LOG2, 2: log2 of the number of periods averaged, 0..4.
- TIMEOUT, 65535: clk_fst cycles allowed without a rising edge before the channel is abandoned.

Ports:
- clk_fst  in  1: measurement clock. All logic runs on clk_fst.
- reset_n  in  1: reset reset_n, synchronous, active-low; clock clk_fst.
- clk_slw_in  in  N_CH: asynchronous slow clocks. Each is internally 2-flop synchronized.
- start  in  1: pulse that starts a scan. Accepted only in IDLE.
- ch_mask  in  N_CH: channels to scan. Sampled on the accepted start.
- continuous  in  1: 1 = restart the scan after the last masked channel.
- busy  out  1: scan in progress.
- done  out  1: one-cycle pulse when a non-continuous scan ends.
- res_valid  out  1: result available.
- res_ready  in  1: result consumer ready.
- res_ch  out  4: channel index of the result.
- res_ht  out  16: averaged high time, in clk_fst cycles.
- res_lt  out  16: averaged low time, in clk_fst cycles.
- res_timeout  out  1: channel produced no edge within TIMEOUT.

## Operation
- FSM states: IDLE, SELECT, SETTLE, MEASURE, REPORT.
- IDLE to SELECT: on start. The FSM latches ch_mask, points at the lowest set bit, and asserts busy.
- Empty mask on start: done pulses the next cycle, busy stays 0, no result is produced.
- SELECT (1 cycle): switch the mux to the current channel, clear the counter, the accumulators and the timeout counter, then go to SETTLE.
- Per-period counting:
  - ht = number of cycles the synchronized sample is 1 between a rising edge and the next falling edge.
  - lt = number of 0 cycles between that falling edge and the next rising edge.
  - A period completes at a rising edge that was preceded by a full high phase and a full low phase. That edge also starts the next period.
  - The partial period present after SELECT is never counted.
- SETTLE: count SETTLE_PERIODS complete periods and discard them, then go to MEASURE.
- MEASURE: accumulate ht and lt over 2^AVG_LOG2 periods into 20-bit sums. Then res_ht = sum_ht >> AVG_LOG2 and res_lt = sum_lt >> AVG_LOG2, both truncating. Go to REPORT.
- Saturation: per-period counters saturate at 0xFFFF, and averaged outputs saturate at 0xFFFF.
- Timeout:
  - The timeout counter resets on every synchronized rising edge.
  - Reaching TIMEOUT in SETTLE or MEASURE jumps to REPORT with res_timeout=1 and res_ht=res_lt=0.
- REPORT:
  - res_valid=1, and res_ch, res_ht, res_lt and res_timeout are held stable until res_valid && res_ready.
  - After the handshake, move to the next set mask bit in ascending order and go to SELECT.
  - Past the highest set bit: if continuous=1, wrap to the lowest set bit. If continuous=0, go to IDLE, pulse done, and drop busy in the same cycle.
- continuous is sampled only at that wrap decision.
- start is ignored while busy. There is no abort input; reset_n is the only abort.

## Timing
- Reset values: busy=0, done=0, res_valid=0, res_ch=0, res_ht=0, res_lt=0, res_timeout=0. FSM in IDLE, synchronizers 0.
- Reset mid-scan: all state returns to these values on the next clk_fst edge. A pending result is lost.
- busy rises on the cycle after the accepted start.
- Synchronizer latency is 2 cycles. Edge detection adds 1 cycle.
- res_valid asserts 1 cycle after the completing edge of the last averaged period, or 1 cycle after the timeout is reached.
- A handshake in cycle t means SELECT occupies t+1, or IDLE with done=1 in t+1.
- res_ready may be high before res_valid. No combinational path from res_ready to any output.
- Simultaneous rising edge and timeout terminal count: the edge wins, and the timeout counter clears.

## Structure
- clk_meas_pkg holds:
  - the state enum;
  - CNT_W=16 and ACC_W=CNT_W+4;
  - the saturating-add helper function.
- Sub-module clk_hilo_counter:
  - inputs: synchronized sample and clear;
  - outputs: period_done strobe, per-period ht/lt, and rise strobe.
- The mux, FSM, accumulators and timeout counter live in clk_meas_sched.

## Test plan
- N_CH=4, mask=0b0101, continuous=0. Ch0 at 20-cycle period (8 high / 12 low), ch2 at 10 (5/5), res_ready=1:
  - results (0,8,12,0) then (2,5,5,0);
  - done pulses once;
  - busy falls with done.
- Ch1 held at 0 and TIMEOUT=1000, mask=0b0010: one result (1,0,0,timeout=1) roughly 1000 cycles after SELECT, then done.
- Backpressure: hold res_ready=0 for 50 cycles during REPORT. Outputs stay stable, there are no extra results, and the next channel starts the cycle after the handshake.
- start with mask=0: done pulses 1 cycle later, res_valid never asserts, start during busy is ignored.
- continuous=1, mask=0b1000:
  - results repeat for ch3;
  - after continuous drops, exactly one more result, then done.
- reset_n=0 during MEASURE: all outputs 0 on the next edge. A new start measures from scratch, with the settle periods counted again.
